sprite_rom_arbiter: RTL
=======================

// Module: sprite_rom_arbiter
// PURPOSE
//  Shares one single-port 16-bit sprite image ROM (altsyncram, registered address, unregistered q)
//  between the VGA sprite-fetch engine (video) and the HPS lightweight-bridge Avalon-MM read port (host).
//  Grants at most one read per cycle, drives the ROM address/chipselect and returns data tagged to its owner.
//  Sits between the sprite renderer and each *_win / sprite ROM instance.
// PARAMETERS
//  ROM_AW     11    ROM address width
//  ROM_DW     16    ROM data width
//  ROM_DEPTH  1536  valid words; addresses >= ROM_DEPTH are out of range
//  STARVE_MAX 15    host wait cycles before forced host grant (used only with SPRITE_ARB_STARVE_GUARD_EN)
// PORTS
//  clk               in   1       system clock
//  reset             in   1       synchronous, active-high reset
//  vid_req           in   1       video read request (level; held until granted)
//  vid_addr          in   ROM_AW  video word address
//  vid_gnt           out  1       video request accepted this cycle (combinational)
//  vid_rvalid        out  1       video read data valid
//  vid_rdata         out  ROM_DW  video read data
//  hst_address       in   ROM_AW  host word address
//  hst_read          in   1       host Avalon read
//  hst_waitrequest   out  1       host Avalon waitrequest
//  hst_readdatavalid out  1       host Avalon readdatavalid
//  hst_readdata      out  ROM_DW  host Avalon readdata
//  rom_address       out  ROM_AW  to ROM address
//  rom_chipselect    out  1       to ROM chipselect
//  rom_clken         out  1       to ROM clken
//  rom_readdata      in   ROM_DW  from ROM q (valid 1 cycle after address)
//  oor_sticky        out  1       set on any out-of-range granted access; cleared only by reset
// BEHAVIOUR
//  - Reset: vid_rvalid=0, hst_readdatavalid=0, vid_rdata=0, hst_readdata=0, oor_sticky=0, pipeline owners=NONE;
//    in-flight reads are dropped and produce no valid. rom_clken=~reset; rom_chipselect=0 in reset.
//  - Arbitration (cycle N, combinational): video wins if vid_req; else host wins if hst_read.
//    vid_gnt=grant_vid; hst_waitrequest = hst_read & ~grant_hst. Exactly one or zero grants per cycle.
//  - rom_address = granted address (video if none granted); rom_chipselect = grant & (addr < ROM_DEPTH).
//  - Pipeline: stage1 reg (end of N) holds owner + oor bit; cycle N+1 ROM q sampled into stage2 reg;
//    valid/data presented in cycle N+2. Fixed latency 2 cycles grant->valid; throughput 1 read/cycle.
//  - Out of range: access still granted and pipelined; returned data forced to 0; oor_sticky set at N+1.
//  - Owner tag routes data: only the owner's valid pulses (1 cycle); the other data output holds its last value.
//  - Back-to-back grants to alternating owners are legal; no bubble inserted.
//  - Simultaneous vid_req and hst_read: video granted, host waits (waitrequest high).
//  - Host must hold hst_address/hst_read stable while waitrequest high (Avalon rule); video likewise while ~vid_gnt.
// CONFIGURATION
//  SPRITE_ARB_STARVE_GUARD_EN defined: wait counter (4 bits min, saturating) increments each cycle
//    hst_read & waitrequest; when count == STARVE_MAX and hst_read, host is granted over video for one cycle
//    (vid_gnt=0), counter clears on any host grant or reset.
//  Not defined: strict video priority; host may starve indefinitely; STARVE_MAX ignored; no counter logic.
// STRUCTURE
//  Package sprite_arb_pkg: owner_t enum {OWN_NONE, OWN_VID, OWN_HST}; ROM_AW/ROM_DW/ROM_DEPTH defaults;
//    stage record type {owner_t owner; logic oor;}.
//  One sub-module: sprite_arb_rdpipe (2-stage owner/oor tag pipe + data capture + demux); arbiter logic in top.
// TESTING
//  1 Video only: vid_req with addr 0,1,2 on consecutive cycles -> vid_gnt=1 each; vid_rvalid cycles 2,3,4 with mem[0..2].
//  2 Contention: vid_req and hst_read(addr 5) together for 3 cycles then vid_req=0 -> host granted cycle 3,
//    hst_readdatavalid at cycle 5 with mem[5]; waitrequest high cycles 0-2.
//  3 Out of range: host read addr 1600 -> rom_chipselect=0, hst_readdata=16'h0000 at +2, oor_sticky=1 until reset.
//  4 Reset mid-flight: grant video at N, reset at N+1 -> no vid_rvalid at N+2; all outputs at reset values.
//  5 Guard (EN defined): vid_req held high, hst_read high -> host granted exactly at 16th wait cycle, vid_gnt=0 that cycle;
//    without macro host never granted while vid_req high.
//  6 Alternating: vid,hst,vid grants back-to-back -> valids on correct port each cycle, data matches ROM image.

Source files
------------

// File: rtl/sprite_arb_pkg.sv
// rtl/sprite_arb_pkg.sv - shared types, defaults and helpers for the sprite ROM arbiter
package sprite_arb_pkg;

    localparam int unsigned DEF_ROM_AW     = 11;
    localparam int unsigned DEF_ROM_DW     = 16;
    localparam int unsigned DEF_ROM_DEPTH  = 1536;
    localparam int unsigned DEF_STARVE_MAX = 15;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_HST  = 2'd2
    } owner_t;

    typedef struct packed {
        owner_t owner;
        logic   oor;
    } stage_t;

    // Host wait counter is never narrower than 4 bits.
    function automatic int unsigned starve_cnt_width(input int unsigned max_count);
        int unsigned w;
        w = $clog2(max_count + 1);
        return (w < 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/sprite_arb_rdpipe.sv
// rtl/sprite_arb_rdpipe.sv - 2-stage owner/oor tag pipe, ROM data capture and per-owner demux
module sprite_arb_rdpipe
    import sprite_arb_pkg::*;
#(
    parameter int unsigned ROM_DW = DEF_ROM_DW
) (
    input  logic              clk,
    input  logic              reset,
    input  stage_t            issue_i,
    input  logic [ROM_DW-1:0] rom_q_i,
    output logic              vid_rvalid_o,
    output logic [ROM_DW-1:0] vid_rdata_o,
    output logic              hst_rvalid_o,
    output logic [ROM_DW-1:0] hst_rdata_o,
    output logic              oor_sticky_o
);

    stage_t            s1_q, s1_d;
    logic              vid_rvalid_q, vid_rvalid_d;
    logic              hst_rvalid_q, hst_rvalid_d;
    logic [ROM_DW-1:0] vid_rdata_q, vid_rdata_d;
    logic [ROM_DW-1:0] hst_rdata_q, hst_rdata_d;
    logic              sticky_q, sticky_d;
    logic [ROM_DW-1:0] cap_data;

    always_comb begin
        s1_d         = issue_i;
        // ROM q is meaningless for out-of-range words; return zero instead.
        cap_data     = s1_q.oor ? '0 : rom_q_i;
        vid_rvalid_d = (s1_q.owner == OWN_VID);
        hst_rvalid_d = (s1_q.owner == OWN_HST);
        vid_rdata_d  = vid_rvalid_d ? cap_data : vid_rdata_q;
        hst_rdata_d  = hst_rvalid_d ? cap_data : hst_rdata_q;
        sticky_d     = sticky_q | ((issue_i.owner != OWN_NONE) & issue_i.oor);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q         <= '{owner: OWN_NONE, oor: 1'b0};
            vid_rvalid_q <= 1'b0;
            hst_rvalid_q <= 1'b0;
            vid_rdata_q  <= '0;
            hst_rdata_q  <= '0;
            sticky_q     <= 1'b0;
        end else begin
            s1_q         <= s1_d;
            vid_rvalid_q <= vid_rvalid_d;
            hst_rvalid_q <= hst_rvalid_d;
            vid_rdata_q  <= vid_rdata_d;
            hst_rdata_q  <= hst_rdata_d;
            sticky_q     <= sticky_d;
        end
    end

    assign vid_rvalid_o = vid_rvalid_q;
    assign vid_rdata_o  = vid_rdata_q;
    assign hst_rvalid_o = hst_rvalid_q;
    assign hst_rdata_o  = hst_rdata_q;
    assign oor_sticky_o = sticky_q;

endmodule

// File: rtl/sprite_rom_arbiter.sv
// rtl/sprite_rom_arbiter.sv - video/host arbiter for a shared single-port sprite ROM
// Optional host anti-starvation guard: SPRITE_ARB_STARVE_GUARD_EN
module sprite_rom_arbiter
    import sprite_arb_pkg::*;
#(
    parameter int unsigned ROM_AW    = DEF_ROM_AW,
    parameter int unsigned ROM_DW    = DEF_ROM_DW,
    parameter int unsigned ROM_DEPTH = DEF_ROM_DEPTH
`ifdef SPRITE_ARB_STARVE_GUARD_EN
    ,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ROM_AW-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [ROM_DW-1:0] vid_rdata,
    input  logic [ROM_AW-1:0] hst_address,
    input  logic              hst_read,
    output logic              hst_waitrequest,
    output logic              hst_readdatavalid,
    output logic [ROM_DW-1:0] hst_readdata,
    output logic [ROM_AW-1:0] rom_address,
    output logic              rom_chipselect,
    output logic              rom_clken,
    input  logic [ROM_DW-1:0] rom_readdata,
    output logic              oor_sticky
);

    logic              grant_vid;
    logic              grant_hst;
    logic              force_hst;
    logic [ROM_AW-1:0] sel_addr;
    logic              in_range;
    stage_t            issue;

`ifdef SPRITE_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = starve_cnt_width(STARVE_MAX);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        force_hst  = hst_read & (wait_cnt_q == CNT_W'(STARVE_MAX));
        wait_cnt_d = wait_cnt_q;
        if (grant_hst) begin
            wait_cnt_d = '0;
        end else if (hst_read && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign force_hst = 1'b0;
`endif

    // No request is accepted while in reset so nothing enters the pipe.
    always_comb begin
        grant_vid = ~reset & vid_req & ~force_hst;
        grant_hst = ~reset & hst_read & (~vid_req | force_hst);
        sel_addr  = grant_hst ? hst_address : vid_addr;
        in_range  = (32'(sel_addr) < ROM_DEPTH);

        issue.owner = OWN_NONE;
        issue.oor   = 1'b0;
        if (grant_vid) begin
            issue.owner = OWN_VID;
            issue.oor   = ~in_range;
        end else if (grant_hst) begin
            issue.owner = OWN_HST;
            issue.oor   = ~in_range;
        end
    end

    assign vid_gnt         = grant_vid;
    assign hst_waitrequest = hst_read & ~grant_hst;
    assign rom_address     = sel_addr;
    assign rom_chipselect  = (grant_vid | grant_hst) & in_range;
    assign rom_clken       = ~reset;

    sprite_arb_rdpipe #(
        .ROM_DW (ROM_DW)
    ) u_rdpipe (
        .clk          (clk),
        .reset        (reset),
        .issue_i      (issue),
        .rom_q_i      (rom_readdata),
        .vid_rvalid_o (vid_rvalid),
        .vid_rdata_o  (vid_rdata),
        .hst_rvalid_o (hst_readdatavalid),
        .hst_rdata_o  (hst_readdata),
        .oor_sticky_o (oor_sticky)
    );

endmodule
